// File: rtl/wvb_readout_framer.sv
// wvb_readout_framer
// Drains the mDOM waveform buffer one waveform at a time and emits a framed
// 16-bit word stream: a start word, five header words, then a HI/LO word pair
// for every sample. The waveform is handed back to the buffer with a
// one-cycle rddone pulse once its last word has been accepted downstream.
// P_DATA_WIDTH is expected in 17..32 and P_HDR_WIDTH is fixed at 80.

module wvb_readout_framer #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_CHAN_ID    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    // header FIFO (show-ahead)
    input  logic [P_HDR_WIDTH-1:0]  hdr_data_out,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    // waveform RAM
    input  logic [P_DATA_WIDTH-1:0] wvb_data_out,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    // framed word stream
    output logic [15:0]             dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    input  logic                    dout_ready,
    // status
    output logic                    busy,
    output logic [15:0]             wvf_count
);

    // Sample counter is one bit wider than the length field so that an
    // all-ones field (length-1 encoding) becomes a full 2**P_ADR_WIDTH count.
    localparam int CNT_W = P_ADR_WIDTH + 1;

    localparam logic [7:0] FRAME_MARK = 8'hA5;
    localparam logic [7:0] CHAN_TAG   = 8'(P_CHAN_ID);
    localparam logic [2:0] LAST_HDR_IDX = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_TX,
        ST_S_REQ,
        ST_S_WAIT,
        ST_S_HI,
        ST_S_LO
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [P_HDR_WIDTH-1:0]  hdr_q;
    logic [P_DATA_WIDTH-1:0] samp_q;
    logic [CNT_W-1:0]        samp_left_q;
    logic [2:0]              word_idx_q;
    logic [15:0]             wvf_count_q;

    logic [CNT_W-1:0]        n_samp;
    logic [15:0]             hdr_word;
    logic [31:0]             samp_ext;
    logic [15:0]             hi_word;
    logic [15:0]             lo_word;
    logic                    last_samp;

    // ------------------------------------------------------------------
    // Word formatting
    // ------------------------------------------------------------------

    assign n_samp    = {1'b0, hdr_data_out[P_ADR_WIDTH-1:0]} + CNT_W'(1);
    assign samp_ext  = 32'(samp_q);
    assign hi_word   = samp_ext[31:16];
    assign lo_word   = samp_q[15:0];
    assign last_samp = (samp_left_q == '0);

    // Select the start word or one of the five latched header words.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the case can leave it unassigned (latch).
        hdr_word = 16'h0000;
        case (word_idx_q)
            3'd0:    hdr_word = {FRAME_MARK, CHAN_TAG};
            3'd1:    hdr_word = hdr_q[79:64];
            3'd2:    hdr_word = hdr_q[63:48];
            3'd3:    hdr_word = hdr_q[47:32];
            3'd4:    hdr_word = hdr_q[31:16];
            3'd5:    hdr_word = hdr_q[15:0];
            default: hdr_word = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and all handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        hdr_rdreq  = 1'b0;
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        dout       = 16'h0000;
        dout_valid = 1'b0;
        dout_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_n is included so the pop strobe stays low while reset
                // is held, even with a header waiting and en high.
                if (en && !hdr_empty && rst_n) begin
                    hdr_rdreq = 1'b1;
                    state_d   = ST_HDR_TX;
                end
            end

            ST_HDR_TX: begin
                dout_valid = 1'b1;
                dout       = hdr_word;
                if (dout_ready && (word_idx_q == LAST_HDR_IDX)) begin
                    state_d = ST_S_REQ;
                end
            end

            ST_S_REQ: begin
                wvb_rdreq = 1'b1;
                state_d   = ST_S_WAIT;
            end

            ST_S_WAIT: begin
                // Read data is valid this cycle; it is latched below.
                state_d = ST_S_HI;
            end

            ST_S_HI: begin
                dout_valid = 1'b1;
                dout       = hi_word;
                if (dout_ready) begin
                    state_d = ST_S_LO;
                end
            end

            ST_S_LO: begin
                dout_valid = 1'b1;
                dout       = lo_word;
                dout_last  = last_samp;
                if (dout_ready) begin
                    if (last_samp) begin
                        wvb_rddone = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_S_REQ;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Header latch, header word index, sample latch and samples remaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the 80-bit header holding register is cleared on reset
            // like any other flop; it is a register, not a RAM, so this is
            // cheap and keeps a stale header from ever reaching dout.
            hdr_q       <= '0;
            samp_q      <= '0;
            samp_left_q <= '0;
            word_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_rdreq) begin
                        hdr_q       <= hdr_data_out;
                        samp_left_q <= n_samp;
                        word_idx_q  <= '0;
                    end
                end
                ST_HDR_TX: begin
                    if (dout_ready) begin
                        word_idx_q <= (word_idx_q == LAST_HDR_IDX) ? 3'd0
                                                                   : word_idx_q + 3'd1;
                    end
                end
                ST_S_WAIT: begin
                    samp_q      <= wvb_data_out;
                    samp_left_q <= samp_left_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvf_count_q <= '0;
        end else if (wvb_rddone) begin
            wvf_count_q <= wvf_count_q + 16'd1;
        end
    end

    assign wvf_count = wvf_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wvb_readout_framer.sv
// tb_wvb_readout_framer
// Directed bench for wvb_readout_framer: a small header-FIFO / waveform-RAM
// model feeds the framer, a negedge monitor captures every accepted word and
// counts strobes, and the expected stream is rebuilt from the header and
// sample contents the bench itself loaded.

module tb_wvb_readout_framer;

    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [79:0]   hdr_data_out;
    logic          hdr_empty;
    logic          hdr_rdreq;
    logic [DW-1:0] wvb_data_out;
    logic          wvb_rdreq;
    logic          wvb_rddone;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_last;
    logic          dout_ready;
    logic          busy;
    logic [15:0]   wvf_count;

    always #5 clk = ~clk;

    wvb_readout_framer #(
        .P_DATA_WIDTH(DW),
        .P_ADR_WIDTH (12),
        .P_HDR_WIDTH (80),
        .P_CHAN_ID   (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hdr_data_out(hdr_data_out),
        .hdr_empty   (hdr_empty),
        .hdr_rdreq   (hdr_rdreq),
        .wvb_data_out(wvb_data_out),
        .wvb_rdreq   (wvb_rdreq),
        .wvb_rddone  (wvb_rddone),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_last   (dout_last),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .wvf_count   (wvf_count)
    );

    // ---------------- buffer model ----------------
    logic [79:0]   hdr_mem [16];
    int            hdr_wr = 0;     // written by main initial only
    int            hdr_rd = 0;     // advanced by pops only
    logic [DW-1:0] samp_mem [4096];
    int            samp_ptr;

    assign hdr_empty    = (hdr_wr == hdr_rd);
    assign hdr_data_out = hdr_mem[hdr_rd % 16];

    always @(posedge clk) begin
        if (hdr_rdreq) hdr_rd <= hdr_rd + 1;
    end

    // RAM data is only meaningful the cycle after a read; filler otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_ptr     <= 0;
            wvb_data_out <= '0;
        end else begin
            wvb_data_out <= 22'h2AAAAA;
            if (wvb_rdreq) begin
                wvb_data_out <= samp_mem[samp_ptr];
                samp_ptr     <= samp_ptr + 1;
            end
            if (wvb_rddone) samp_ptr <= 0;
        end
    end

    // ---------------- monitor ----------------
    logic [15:0] rx_word [16384];
    logic        rx_last [16384];
    int rx_n = 0, pops = 0, rdreqs = 0, rddones = 0, cyc = 0;
    int last_done_cyc = 0, pop_gap = -1, proto_errs = 0;
    int stall_checks = 0, stall_errs = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [15:0] prev_d = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (dout_valid && dout_ready && rx_n < 16384) begin
                rx_word[rx_n] <= dout;
                rx_last[rx_n] <= dout_last;
                rx_n          <= rx_n + 1;
            end
            if (hdr_rdreq) begin
                pops    <= pops + 1;
                pop_gap <= cyc - last_done_cyc;
                if (busy) proto_errs <= proto_errs + 1;
            end
            if (wvb_rdreq) rdreqs <= rdreqs + 1;
            if (wvb_rddone) begin
                rddones       <= rddones + 1;
                last_done_cyc <= cyc;
            end
            if (prev_v && !prev_r) begin
                stall_checks <= stall_checks + 1;
                if (!dout_valid || dout != prev_d || dout_last != prev_l)
                    stall_errs <= stall_errs + 1;
            end
            prev_v <= dout_valid;
            prev_r <= dout_ready;
            prev_d <= dout;
            prev_l <= dout_last;
        end
    end

    // ---------------- downstream ready driver ----------------
    bit          bp_mode = 1'b0;
    logic [15:0] lfsr = 16'hACE1;

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            dout_ready = bp_mode ? lfsr[0] : 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected word k of a frame built from header h and the loaded samples.
    function automatic logic [15:0] model_word(input logic [79:0] h, input int k);
        logic [DW-1:0] s;
        logic [15:0]   w;
        if (k == 0) begin
            w = 16'hA500;
        end else if (k <= 5) begin
            w = h[79-16*(k-1) -: 16];
        end else begin
            s = samp_mem[(k-6)/2];
            if (((k - 6) % 2) == 0) w = {10'b0, s[DW-1:16]};
            else                    w = s[15:0];
        end
        return w;
    endfunction

    function automatic int word_errs(input int start, input logic [79:0] h, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (rx_word[start+k] !== model_word(h, k)) e++;
        return e;
    endfunction

    function automatic int last_errs(input int start, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (rx_last[start+k] !== (k == n - 1)) e++;
        return e;
    endfunction

    task automatic push_hdr(input logic [79:0] h);
        hdr_mem[hdr_wr % 16] = h;
        hdr_wr++;
    endtask

    task automatic fill_samples(input int seed);
        if (seed < 0) begin
            samp_mem[0] = 22'h3ABCDE;
            samp_mem[1] = 22'h000001;
            samp_mem[2] = 22'h155555;
        end else begin
            for (int i = 0; i < 4096; i++)
                samp_mem[i] = DW'(i * 32'h2545F + seed * 32'h1357);
        end
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int c = 0; c < budget && rddones < target; c++) tick(1);
        check({tag, " rddone reached"}, 64'(rddones >= target), 64'd1);
    endtask

    typedef struct {
        logic [79:0] hdr;
        bit          bp;
        int          seed;
        int          exp_words;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] golden [12];
    int          exp_count;
    int          r0, p0, q0, d0;

    initial begin
        vecs[0] = '{80'h0123_4567_89AB_CDEF_0002, 1'b0, -1, 12};
        vecs[1] = '{80'h0123_4567_89AB_CDEF_0002, 1'b1, -1, 12};
        vecs[2] = '{80'hFEDC_BA98_7654_3210_F000, 1'b0,  7, 8};
        vecs[3] = '{80'h1111_2222_3333_4444_5FFF, 1'b0,  3, 8198};
        golden  = '{16'hA500, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0002,
                    16'h003A, 16'hBCDE, 16'h0000, 16'h0001, 16'h0015, 16'h5555};

        // ---- reset state ----
        rst_n = 1'b0;
        en    = 1'b1;
        tick(3);
        check("reset outputs",
              64'({dout, dout_valid, dout_last, busy, hdr_rdreq, wvb_rdreq, wvb_rddone}), 64'd0);
        check("reset wvf_count", 64'(wvf_count), 64'd0);
        en    = 1'b0;
        rst_n = 1'b1;
        tick(2);
        exp_count = 0;

        // ---- table-driven frames ----
        foreach (vecs[v]) begin
            fill_samples(vecs[v].seed);
            r0 = rx_n; p0 = pops; q0 = rdreqs; d0 = rddones;
            push_hdr(vecs[v].hdr);
            bp_mode = vecs[v].bp;
            en = 1'b1;
            wait_done($sformatf("vec%0d", v), d0 + 1, 20 * vecs[v].exp_words + 100);
            en = 1'b0;
            bp_mode = 1'b0;
            tick(4);
            exp_count++;
            check($sformatf("vec%0d word count", v), 64'(rx_n - r0), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d word errors", v), 64'(word_errs(r0, vecs[v].hdr, vecs[v].exp_words)), 64'd0);
            check($sformatf("vec%0d last errors", v), 64'(last_errs(r0, vecs[v].exp_words)), 64'd0);
            check($sformatf("vec%0d hdr pops", v), 64'(pops - p0), 64'd1);
            check($sformatf("vec%0d wvb rdreqs", v), 64'(rdreqs - q0), 64'((vecs[v].exp_words - 6) / 2));
            check($sformatf("vec%0d rddones", v), 64'(rddones - d0), 64'd1);
            check($sformatf("vec%0d wvf_count", v), 64'(wvf_count), 64'(exp_count));
            check($sformatf("vec%0d idle", v), 64'(busy), 64'd0);
            if (v <= 1) begin
                for (int k = 0; k < 12; k++)
                    check($sformatf("vec%0d golden w%0d", v, k), 64'(rx_word[r0+k]), 64'(golden[k]));
            end
        end
        check("stalls observed", 64'(stall_checks > 0), 64'd1);

        // ---- enable / empty ----
        p0 = pops; q0 = rdreqs;
        en = 1'b1;
        tick(10);
        check("empty: no pop", 64'(pops - p0), 64'd0);
        check("empty: no rdreq", 64'(rdreqs - q0), 64'd0);
        check("empty: idle", 64'(busy), 64'd0);
        en = 1'b0;
        fill_samples(-1);
        push_hdr(vecs[0].hdr);
        tick(10);
        check("en=0: no pop", 64'(pops - p0), 64'd0);
        check("en=0: idle", 64'(busy), 64'd0);

        push_hdr(vecs[0].hdr);
        push_hdr(vecs[0].hdr);
        r0 = rx_n; d0 = rddones;
        en = 1'b1;
        for (int c = 0; c < 50 && rdreqs == q0; c++) tick(1);
        en = 1'b0;
        wait_done("en drop", d0 + 1, 200);
        tick(20);
        exp_count++;
        check("en drop: one pop", 64'(pops - p0), 64'd1);
        check("en drop: words", 64'(rx_n - r0), 64'd12);
        check("en drop: word errors", 64'(word_errs(r0, vecs[0].hdr, 12)), 64'd0);
        check("en drop: idle", 64'(busy), 64'd0);

        r0 = rx_n; d0 = rddones;
        en = 1'b1;
        @(negedge clk);
        check("re-enable: pop in first idle cycle", 64'(hdr_rdreq), 64'd1);
        tick(1);
        wait_done("b2b", d0 + 2, 400);
        en = 1'b0;
        tick(4);
        exp_count += 2;
        check("b2b: gap rddone->pop", 64'(pop_gap), 64'd1);
        check("b2b: words", 64'(rx_n - r0), 64'd24);
        check("b2b: frame1 errors", 64'(word_errs(r0, vecs[0].hdr, 12)), 64'd0);
        check("b2b: frame2 errors", 64'(word_errs(r0 + 12, vecs[0].hdr, 12)), 64'd0);
        check("b2b: wvf_count", 64'(wvf_count), 64'(exp_count));
        check("no pop while busy", 64'(proto_errs), 64'd0);

        // ---- reset mid-frame (S_HI of sample 2) ----
        q0 = rdreqs; d0 = rddones;
        push_hdr(vecs[0].hdr);
        en = 1'b1;
        for (int c = 0; c < 100 && rdreqs < q0 + 2; c++) tick(1);
        tick(1);
        check("pre-reset HI valid", 64'({busy, dout_valid, dout}), 64'({1'b1, 1'b1, 16'h0000}));
        rst_n = 1'b0;
        #1;
        check("mid reset outputs",
              64'({dout, dout_valid, dout_last, busy, hdr_rdreq, wvb_rdreq, wvb_rddone}), 64'd0);
        check("mid reset wvf_count", 64'(wvf_count), 64'd0);
        en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("reset: no rddone", 64'(rddones - d0), 64'd0);
        check("reset: no extra rdreq", 64'(rdreqs - q0), 64'd2);
        exp_count = 0;

        fill_samples(11);
        r0 = rx_n; d0 = rddones;
        push_hdr(80'hAAAA_BBBB_CCCC_DDDD_E001);
        en = 1'b1;
        wait_done("post-reset", d0 + 1, 200);
        en = 1'b0;
        tick(4);
        exp_count++;
        check("post-reset first word", 64'(rx_word[r0]), 64'h0000_0000_0000_A500);
        check("post-reset words", 64'(rx_n - r0), 64'd10);
        check("post-reset errors", 64'(word_errs(r0, 80'hAAAA_BBBB_CCCC_DDDD_E001, 10)), 64'd0);
        check("post-reset wvf_count", 64'(wvf_count), 64'(exp_count));

        // ---- counter wrap (preloaded near the top) ----
        force dut.wvf_count_q = 16'hFFFE;
        tick(1);
        release dut.wvf_count_q;
        tick(1);
        fill_samples(5);
        for (int f = 0; f < 2; f++) begin
            d0 = rddones;
            push_hdr(80'h0000_0000_0000_0000_0000);
            en = 1'b1;
            wait_done($sformatf("wrap%0d", f), d0 + 1, 200);
            en = 1'b0;
            tick(3);
            check($sformatf("wrap%0d wvf_count", f), 64'(wvf_count), (f == 0) ? 64'hFFFF : 64'h0000);
        end

        check("stall stability", 64'(stall_errs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wvb_readout_framer.md
Name: wvb_readout_framer

Overview:
- Downstream consumer of the mDOM waveform buffer reader interface (header FIFO plus waveform RAM).
- Pops one header per buffered waveform and reads that waveform's samples in order.
- Serialises the header and samples into a framed 16-bit word stream with valid/ready/last, for the readout DMA/serial link.
- Releases each waveform back to the buffer with a one-cycle rddone pulse.

Parameters:
P_DATA_WIDTH, 22, waveform sample width; must be 17..32.
P_ADR_WIDTH, 12, sample-count field width in header.
P_HDR_WIDTH, 80, header width; fixed at 80 (5 words).
P_CHAN_ID, 0, 8-bit channel tag placed in the frame start word.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  readout enable; sampled only in IDLE
hdr_data_out  in  P_HDR_WIDTH  show-ahead header; valid whenever hdr_empty=0
hdr_empty  in  1  header FIFO empty
hdr_rdreq  out  1  header pop, one-cycle pulse
wvb_data_out  in  P_DATA_WIDTH  sample; valid exactly 1 cycle after wvb_rdreq
wvb_rdreq  out  1  sample read, one-cycle pulse
wvb_rddone  out  1  waveform fully read, one-cycle pulse
dout  out  16  frame word
dout_valid  out  1  word valid
dout_last  out  1  final word of frame
dout_ready  in  1  downstream accept
busy  out  1  high in any state except IDLE
wvf_count  out  16  frames completed; wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; header latch, sample latch and counters cleared. Reset mid-frame abandons the frame with no rddone and no further rdreq. The buffer is reset on the same domain reset.
- Handshake: a word transfers on a cycle with dout_valid && dout_ready. While valid && !ready, dout and dout_last hold stable. dout_valid never drops without a transfer.
- Header fields:
  - n_samp = hdr[P_ADR_WIDTH-1:0] + 1, computed at P_ADR_WIDTH+1 bits. An all-ones field means 4096 samples with no overflow.
  - The rest of the header is opaque.
- Frame format: W0={8'hA5,P_CHAN_ID[7:0]}; W1..W5=hdr[79:64],[63:48],[47:32],[31:16],[15:0]; then per sample HI={zero-pad,s[P_DATA_WIDTH-1:16]}, LO=s[15:0]. Total words = 6 + 2*n_samp. dout_last is asserted only on LO of the final sample.
- States:
  - IDLE: if en && !hdr_empty, latch hdr_data_out, pulse hdr_rdreq that cycle, load samp_left=n_samp, go to HDR_TX. Otherwise stay.
  - HDR_TX: present W0..W5, advancing word index on each transfer. After W5 transfers, go to S_REQ.
  - S_REQ: pulse wvb_rdreq, go to S_WAIT.
  - S_WAIT: latch wvb_data_out, decrement samp_left, go to S_HI.
  - S_HI: present HI; on transfer go to S_LO.
  - S_LO: present LO, with dout_last when samp_left==0. On transfer: if samp_left!=0 go to S_REQ; else pulse wvb_rddone, increment wvf_count, go to IDLE.
- Exactly one wvb_rdreq per sample and one hdr_rdreq per frame. No rdreq is issued while hdr_empty=1 in IDLE.
- en deassert mid-frame: the current frame completes. The next frame does not start until en=1.
- Minimum gap: one IDLE cycle between frames (rddone cycle, then IDLE evaluates).
- Back-to-back headers: the second header pops only after the first frame's rddone.
- Latency:
  - hdr_rdreq to W0 valid: 1 cycle.
  - W5 transfer to wvb_rdreq: 1 cycle.
  - wvb_rdreq to HI valid: 2 cycles.
- Throughput with ready held high: 4 cycles per sample.

Test Plan:
- Single frame: hdr=80'h0123_4567_89AB_CDEF_0002 (n_samp=3), samples 22'h3ABCDE, 22'h000001, 22'h155555, ready=1 -> words A500,0123,4567,89AB,CDEF,0002,003A,BCDE,0000,0001,0015,5555; last only on 5555; 3 wvb_rdreq, 1 hdr_rdreq, 1 rddone; wvf_count=1.
- Backpressure: same frame with dout_ready toggled pseudo-randomly -> identical word sequence; dout/dout_last stable during every stall; no lost or duplicated words.
- Boundary lengths: length field 0 -> 8 words, last on word 7. Length field 12'hFFF -> 4096 rdreq, 8198 words, single rddone.
- Enable/empty: hdr_empty=1 or en=0 -> no rdreq, busy=0. en dropped during sample 1 of 3 -> frame completes and no new pop while two headers remain queued. Reasserting en -> the next frame starts with hdr_rdreq in the first IDLE cycle.
- Reset mid-frame: rst_n low during S_HI of sample 2 -> all outputs 0 immediately; no rddone. After release with a new header -> clean frame starting A500.
- Counter wrap: preload run of 65536 minimal frames -> wvf_count returns to 0x0000.
